// File: rtl/lmsm_sequencer.sv
// -----------------------------------------------------------------------------
// lmsm_sequencer
// Load-multiple / store-multiple transfer sequencer. A start pulse latches a
// register bitmask, a direction and a base address. The block then visits the
// set bits in ascending index order. For each set bit it moves one word between
// the register file and consecutive memory addresses through a ready-based
// memory handshake. A one-cycle done pulse ends the operation.
//
// Ports:
//   clk, proc_rst            clock (rising edge), async active-low reset
//   start, mode              begin transfer (IDLE only); 0 = load, 1 = store
//   reg_mask, base_addr      registers to move, first memory address
//   mem_ready, mem_rdata     memory handshake completion, load data
//   rf_rdata                 asynchronous RF read data for rf_raddr
//   busy, done               transfer in progress, completion pulse
//   mem_req/we/addr/wdata    memory request channel
//   rf_raddr                 RF read index (store)
//   rf_wen/waddr/wdata       RF write port (load)
//   xfer_count, end_addr     words moved, base_addr + xfer_count
// -----------------------------------------------------------------------------
module lmsm_sequencer #(
   parameter int NUM_REGS   = 8,
   parameter int REG_ADDR_W = 3,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16
) (
   input  logic                  clk,
   input  logic                  proc_rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [NUM_REGS-1:0]   reg_mask,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic                  mem_ready,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic [DATA_W-1:0]     rf_rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [REG_ADDR_W-1:0] rf_raddr,
   output logic                  rf_wen,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic [REG_ADDR_W:0]   xfer_count,
   output logic [ADDR_W-1:0]     end_addr
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SCAN = 3'd1,
      ST_REQ  = 3'd2,
      ST_WB   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [REG_ADDR_W:0] CNT_ONE  = {{REG_ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0]   ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t                state_r;
   state_t                state_nxt_s;
   logic                  mode_r;
   logic [NUM_REGS-1:0]   pending_r;
   logic [ADDR_W-1:0]     addr_r;
   logic [REG_ADDR_W-1:0] cur_idx_r;
   logic [REG_ADDR_W:0]   count_r;
   logic [DATA_W-1:0]     rdata_r;
   logic [REG_ADDR_W-1:0] scan_idx_s;

   // Index of the lowest set bit; the result is only used when m is non-zero.
   function automatic logic [REG_ADDR_W-1:0] lowest_set(input logic [NUM_REGS-1:0] m);
      logic [REG_ADDR_W-1:0] idx;
      idx = {REG_ADDR_W{1'b0}};
      // Scan downwards so that the last hit, which is the lowest index, wins.
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (m[i]) begin
            idx = REG_ADDR_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Priority encoder over the registers that are still pending.
   always_comb begin
      scan_idx_s = lowest_set(pending_r);
   end

   // State register. An asynchronous reset returns to IDLE at once, so
   // mem_req and rf_wen drop without waiting for a clock edge.
   always_ff @(posedge clk or negedge proc_rst) begin
      if (!proc_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_SCAN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (pending_r == {NUM_REGS{1'b0}}) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_ready) begin
               state_nxt_s = mode_r ? ST_SCAN : ST_WB;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_WB:   state_nxt_s = ST_SCAN;
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Datapath: operation latch, pending mask, address and word counters.
   always_ff @(posedge clk or negedge proc_rst) begin
      if (!proc_rst) begin
         mode_r    <= 1'b0;
         pending_r <= {NUM_REGS{1'b0}};
         addr_r    <= {ADDR_W{1'b0}};
         cur_idx_r <= {REG_ADDR_W{1'b0}};
         count_r   <= {(REG_ADDR_W + 1){1'b0}};
         rdata_r   <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  mode_r    <= mode;
                  pending_r <= reg_mask;
                  addr_r    <= base_addr;
                  count_r   <= {(REG_ADDR_W + 1){1'b0}};
               end
            end
            ST_SCAN: begin
               if (pending_r != {NUM_REGS{1'b0}}) begin
                  cur_idx_r             <= scan_idx_s;
                  pending_r[scan_idx_s] <= 1'b0;
               end
            end
            ST_REQ: begin
               if (mem_ready) begin
                  if (mode_r) begin
                     // Store completes in the handshake cycle itself.
                     addr_r  <= addr_r + ADDR_ONE;
                     count_r <= count_r + CNT_ONE;
                  end else begin
                     // Load data is written back in WB.
                     rdata_r <= mem_rdata;
                  end
               end
            end
            ST_WB: begin
               addr_r  <= addr_r + ADDR_ONE;
               count_r <= count_r + CNT_ONE;
            end
            default: begin
               addr_r <= addr_r;
            end
         endcase
      end
   end

   // Output decode. All outputs come from registered state, except mem_wdata,
   // which passes the asynchronous RF read straight through during a store request.
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      rf_raddr  = {REG_ADDR_W{1'b0}};
      rf_wen    = 1'b0;
      rf_waddr  = {REG_ADDR_W{1'b0}};
      rf_wdata  = {DATA_W{1'b0}};
      case (state_r)
         ST_SCAN: begin
            busy = 1'b1;
         end
         ST_REQ: begin
            busy     = 1'b1;
            mem_req  = 1'b1;
            mem_we   = mode_r;
            mem_addr = addr_r;
            if (mode_r) begin
               rf_raddr  = cur_idx_r;
               mem_wdata = rf_rdata;
            end else begin
               rf_raddr  = {REG_ADDR_W{1'b0}};
               mem_wdata = {DATA_W{1'b0}};
            end
         end
         ST_WB: begin
            busy     = 1'b1;
            rf_wen   = 1'b1;
            rf_waddr = cur_idx_r;
            rf_wdata = rdata_r;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // addr_r advances in step with count_r, so it already equals base + count.
   assign xfer_count = count_r;
   assign end_addr   = addr_r;

endmodule
